logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8) sharing the one logic unit.
REQ-002 Parameter W, default 32, operand and result width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  grant/accept; at most one bit high per cycle.
REQ-007 req_op  input  2*NREQ  per-requester opcode; requester i uses bits [2i+1:2i].
REQ-008 req_a, req_b  input  W*NREQ each  per-requester operands; requester i uses bits [W*i+W-1:W*i].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-012 rsp_data  output  W  operation result.

Function
REQ-013 Opcodes: 00 AND, 01 OR, 10 XOR, 11 NOR; bitwise over all W bits, no carries, no flags.
REQ-014 FSM states: IDLE, EXEC, RESP; no other reachable state.
REQ-015 IDLE: if any req_valid bit is high, the arbiter raises req_ready for exactly one winner in the same cycle (combinational) and latches that winner's op, a, b and id; next state EXEC.
REQ-016 IDLE with no req_valid: req_ready is all zero and the FSM stays in IDLE.
REQ-017 EXEC: the logic unit evaluates the latched operands; the result is registered into rsp_data; next state RESP.
REQ-018 RESP: rsp_valid is high, and rsp_data and rsp_id are held stable until rsp_ready is high; on rsp_valid and rsp_ready the next state is IDLE.
REQ-019 Latency: accept at edge t gives rsp_valid from cycle t+2; minimum spacing between accepts is 3 cycles.
REQ-020 req_ready is zero in EXEC and RESP regardless of req_valid.
REQ-021 Requests are not queued; a requester holds req_valid, op and operands until it sees req_ready.
REQ-022 Arbitration is fair per REQ-031 and REQ-032; the winner is a pure function of req_valid and the priority pointer.
REQ-023 rsp_ready asserted outside RESP is ignored.

Reset
REQ-024 When reset is high at an edge, the FSM goes to IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, and the priority pointer is 0.
REQ-025 Reset mid-operation (EXEC or RESP) discards the in-flight result; no rsp_valid pulse follows.
REQ-026 req_ready is 0 in any cycle in which reset is high.

Configuration
REQ-027 Macro LOGIC_UNIT_ARB_RR_EN selects round-robin arbitration when defined.
REQ-028 Round-robin search starts at the pointer; after each accept, the pointer becomes (winner+1) mod NREQ.
REQ-029 Without the macro, arbitration is fixed priority (lowest index wins); the pointer register is not built.
REQ-030 Ports, latency and FSM behaviour are identical in both builds.
REQ-031 Round-robin guarantee: with all requesters continuously valid, each requester is granted once per NREQ accepts.
REQ-032 Fixed-priority guarantee: requester 0 is never blocked by a higher-index requester.

Structure
REQ-033 A shared package holds the opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOR), the FSM state encodings, and the default W.
REQ-034 The bitwise datapath is a separate sub-module, logic_unit_32bits (inputs op, a, b; output result; purely combinational), instantiated once.
REQ-035 The arbiter and FSM reside in logic_unit_arbiter; there is no other hierarchy.

Verification
REQ-036 Single op: reset, then req_valid=0001, op XOR, a=FFFF0000, b=0F0F0F0F -> req_ready=0001 in the same cycle; rsp_valid two cycles later with rsp_data=F0F00F0F and rsp_id=0.
REQ-037 All opcodes: a=AAAAAAAA, b=CCCCCCCC -> AND 88888888, OR EEEEEEEE, XOR 66666666, NOR 11111111.
REQ-038 Round-robin build, req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; the fixed-priority build grants 0 every time.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable, and req_ready stays 0 throughout.
REQ-040 Reset in EXEC: accept at t, reset at t+1 -> rsp_valid stays 0, the FSM is in IDLE, and the pointer is 0.
REQ-041 Simultaneous rsp_ready and a new req_valid in RESP -> no accept that cycle; the accept occurs in the next IDLE cycle.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter_pkg
//   Shared definitions for the logic-unit arbiter slice.
//   - OP_* : 2-bit opcodes understood by logic_unit_32bits
//   - ST_* : FSM state encodings used by logic_unit_arbiter
//   - DEFAULT_W : default operand/result width
// No ports (package).
// -----------------------------------------------------------------------------
package logic_unit_arbiter_pkg;

  localparam int DEFAULT_W = 32;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

  // Encoding 2'b11 is never entered; the FSM recovers to IDLE if it ever is.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit_32bits
//   Purely combinational bitwise logic unit (no carries, no flags).
//   Ports:
//     op     in  2  opcode (OP_AND / OP_OR / OP_XOR / OP_NOR)
//     a, b   in  W  operands
//     result out W  bitwise result
// -----------------------------------------------------------------------------
module logic_unit_32bits
  import logic_unit_arbiter_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//   Arbitrates NREQ requesters onto one shared bitwise logic unit.
//   FSM: IDLE (grant + latch operands) -> EXEC (compute, register result)
//        -> RESP (hold result until rsp_ready) -> IDLE.
//   Build option: define LOGIC_UNIT_ARB_RR_EN for round-robin arbitration;
//   otherwise fixed priority (lowest index wins) and no pointer register.
//   Ports:
//     clk        in  1          clock, rising edge
//     reset      in  1          synchronous active-high reset
//     req_valid  in  NREQ       per-requester request
//     req_ready  out NREQ       one-hot grant (IDLE only, never during reset)
//     req_op     in  2*NREQ     opcode of requester i at [2i+1:2i]
//     req_a      in  W*NREQ     operand a of requester i at [W*i+W-1:W*i]
//     req_b      in  W*NREQ     operand b of requester i at [W*i+W-1:W*i]
//     rsp_valid  out 1          result available (RESP)
//     rsp_ready  in  1          consumer accepts result
//     rsp_id     out clog2(NREQ) owner of the result
//     rsp_data   out W          result
// -----------------------------------------------------------------------------
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEFAULT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [W*NREQ-1:0]        req_a,
  input  logic [W*NREQ-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data
);

  localparam int IDW = $clog2(NREQ);

  // ---------------------------------------------------------------------------
  // Unpack the flat request buses into per-requester arrays
  // ---------------------------------------------------------------------------
  logic [1:0]   op_arr [NREQ];
  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[2*gi +: 2];
    assign a_arr[gi]  = req_a[W*gi +: W];
    assign b_arr[gi]  = req_b[W*gi +: W];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]     state_q,    state_d;
  logic [1:0]     op_q,       op_d;
  logic [W-1:0]   a_q,        a_d;
  logic [W-1:0]   b_q,        b_d;
  logic [IDW-1:0] id_q,       id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;

`ifdef LOGIC_UNIT_ARB_RR_EN
  logic [IDW-1:0] ptr_q,      ptr_d;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection: a pure function of req_valid (and the pointer)
  // ---------------------------------------------------------------------------
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

`ifdef LOGIC_UNIT_ARB_RR_EN
  // Circular search starting at the pointer; the first valid requester met
  // wins. The index wraps explicitly so non-power-of-two NREQ works.
  int             cand_int;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_int = int'(ptr_q) + k;
      if (cand_int >= NREQ) begin
        cand_int = cand_int - NREQ;
      end
      cand = IDW'(cand_int);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end
`else
  // Fixed priority: scan from the top so the lowest valid index is last
  // to be written and therefore wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(k);
      end
    end
  end
`endif

  // An accept only happens in IDLE and never while reset is asserted, so
  // req_ready is guaranteed low during reset even though it is combinational.
  logic accept;
  assign accept = (state_q == ST_IDLE) && grant_found && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared datapath, fed only from the latched operands
  // ---------------------------------------------------------------------------
  logic [W-1:0] lu_result;

  logic_unit_32bits #(
    .W (W)
  ) u_logic_unit (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (lu_result)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
`ifdef LOGIC_UNIT_ARB_RR_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_arr[grant_idx];
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          id_d    = grant_idx;
          state_d = ST_EXEC;
`ifdef LOGIC_UNIT_ARB_RR_EN
          // Winner drops to lowest priority for the next search.
          ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
`endif
        end
      end

      ST_EXEC: begin
        rsp_data_d = lu_result;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        // rsp_ready only matters here; elsewhere it is ignored.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef LOGIC_UNIT_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The latched owner id doubles as rsp_id; it only changes on an accept,
  // so it is stable for the whole of RESP.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//   Self-checking bench for logic_unit_arbiter (NREQ=4, W=32).
//   Works for both builds; expectations follow LOGIC_UNIT_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [W-1:0]        rsp_data;

  logic_unit_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;   // reference model's priority pointer

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner: the valid requester closest to the pointer going upward with
  // wrap-around (round-robin), or simply the lowest valid index.
  function automatic int model_winner(input logic [3:0] v, input int ptr);
    int best_dist = NREQ;
    int best      = -1;
`ifdef LOGIC_UNIT_ARB_RR_EN
    for (int i = 0; i < NREQ; i++) begin
      int dist = (i - ptr + NREQ) % NREQ;
      if (v[i] && dist < best_dist) begin
        best_dist = dist;
        best      = i;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && best < 0) best = i;
    end
`endif
    return best;
  endfunction

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // ---------------- helpers ----------------
  // Ends just after a falling edge with reset low and the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    #1;
    chk("ready_during_reset", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("ready_during_reset2", req_ready, 0);
    reset     = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
  endtask

  // One full transaction starting in IDLE just after a falling edge.
  // bp = number of extra RESP cycles with rsp_ready low; during those
  // cycles all requesters are valid to show that no grant leaks out.
  task automatic txn_exp(input logic [3:0] v, input logic [7:0] ops,
                         input logic [127:0] as, input logic [127:0] bs,
                         input int exp_id, input logic [31:0] exp_data,
                         input int bp, input string tag);
    req_valid = v;
    req_op    = ops;
    req_a     = as;
    req_b     = bs;
    #1;
    chk({tag, " grant"}, req_ready, 64'(4'b0001 << exp_id));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({tag, " exec_ready"}, req_ready, 0);
    chk({tag, " exec_valid"}, rsp_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " rsp_data"}, rsp_data, exp_data);
    chk({tag, " rsp_id"}, rsp_id, exp_id);
    req_valid = 4'hF;
    req_a     = ~as;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      #1;
      chk({tag, " bp_valid"}, rsp_valid, 1);
      chk({tag, " bp_data"}, rsp_data, exp_data);
      chk({tag, " bp_id"}, rsp_id, exp_id);
      chk({tag, " bp_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk({tag, " resp_handshake_ready"}, req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    chk({tag, " after_rsp_valid"}, rsp_valid, 0);
    $display("txn %s: id=%0d data=%08h", tag, exp_id, exp_data);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  v;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order [5];
    int w;
    logic [3:0]   rv;
    logic [7:0]   rops;
    logic [127:0] ra, rb;
    logic [31:0]  rexp;

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{4'b0001, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 0, 32'hF0F00F0F};
    vecs[1] = '{4'b0001, 2'b00, 32'hAAAAAAAA, 32'hCCCCCCCC, 0, 32'h88888888};
    vecs[2] = '{4'b0010, 2'b01, 32'hAAAAAAAA, 32'hCCCCCCCC, 1, 32'hEEEEEEEE};
    vecs[3] = '{4'b0100, 2'b10, 32'hAAAAAAAA, 32'hCCCCCCCC, 2, 32'h66666666};
    vecs[4] = '{4'b1000, 2'b11, 32'hAAAAAAAA, 32'hCCCCCCCC, 3, 32'h11111111};
    vecs[5] = '{4'b1100, 2'b00, 32'h12345678, 32'hFFFF0000, 2, 32'h12340000};
    vecs[6] = '{4'b1010, 2'b11, 32'h00000000, 32'h00000000, 1, 32'hFFFFFFFF};
    vecs[7] = '{4'b0110, 2'b10, 32'h12345678, 32'h87654321, 1, 32'h95511559};

    // Table: reset before each entry so the pointer is 0 in either build.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      txn_exp(vecs[k].v, {4{vecs[k].op}}, {4{vecs[k].a}}, {4{vecs[k].b}},
              vecs[k].exp_id, vecs[k].exp_data, (k == 3) ? 5 : 0,
              $sformatf("vec%0d", k));
    end

    // IDLE with nothing valid: no grant, no response.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_no_req_ready", req_ready, 0);
      chk("idle_no_req_valid", rsp_valid, 0);
    end

    // All valid, rsp_ready held high: grant order and 3-cycle spacing.
    do_reset();
    for (int k = 0; k < 5; k++) begin
`ifdef LOGIC_UNIT_ARB_RR_EN
      exp_order[k] = k % NREQ;
`else
      exp_order[k] = 0;
`endif
    end
    req_valid = 4'hF;
    req_op    = {4{2'b10}};
    req_a     = {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010};
    req_b     = {4{32'h0000FFFF}};
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), req_ready, 64'(4'b0001 << exp_order[k]));
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("rr_exec_ready%0d", k), req_ready, 0);
      @(negedge clk);
      #1;
      chk($sformatf("rr_resp_ready%0d", k), req_ready, 0);
      chk($sformatf("rr_rsp_id%0d", k), rsp_id, exp_order[k]);
      chk($sformatf("rr_rsp_data%0d", k), rsp_data,
          model_op(2'b10, req_a[32*exp_order[k] +: 32], 32'h0000FFFF));
      $display("rr accept %0d: id=%0d", k, exp_order[k]);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rr_back_to_idle", rsp_valid, 0);

    // Reset while in EXEC discards the result and clears the pointer.
    do_reset();
    req_valid = 4'b0100;
    req_op    = {4{2'b01}};
    req_a     = {4{32'h12121212}};
    req_b     = {4{32'h00FF00FF}};
    #1;
    chk("rst_exec_grant", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_exec_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    req_valid = 4'hF;
    #1;
    chk("rst_exec_idle_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_exec_no_pulse", rsp_valid, 0);
    end
    $display("txn reset_in_exec done");
    m_ptr = 0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      rv   = 4'($urandom_range(1, 15));
      rops = 8'($urandom);
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      w    = model_winner(rv, m_ptr);
      rexp = model_op(rops[2*w +: 2], ra[32*w +: 32], rb[32*w +: 32]);
      txn_exp(rv, rops, ra, rb, w, rexp, int'($urandom_range(0, 2)),
              $sformatf("rand%0d v=%b", k, rv));
      m_ptr = (w + 1) % NREQ;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
